// File: rtl/master_output_sequencer_if.sv
// Bus between the master controller and the output write-back sequencer:
// command fields, memory stall, and per-beat accumulator/SRAM controls.
interface master_output_sequencer_if #(
  parameter int MAX_OUT_ROWS = 128,
  parameter int MAX_OUT_COLS = 128,
  parameter int SYS_ARR_ROWS = 16,
  parameter int SYS_ARR_COLS = 16,
  parameter int ADDR_WIDTH   = 8
);
  localparam int NUM_SUBMATS_M = MAX_OUT_ROWS / SYS_ARR_ROWS;
  localparam int NUM_SUBMATS_N = MAX_OUT_COLS / SYS_ARR_COLS;
  localparam int OR_W = $clog2(MAX_OUT_ROWS);
  localparam int OC_W = $clog2(MAX_OUT_COLS);
  localparam int SM_W = (NUM_SUBMATS_M > 1) ? $clog2(NUM_SUBMATS_M) : 1;
  localparam int SN_W = (NUM_SUBMATS_N > 1) ? $clog2(NUM_SUBMATS_N) : 1;
  localparam int RN_W = $clog2(SYS_ARR_ROWS);

  logic                               start;
  logic [OR_W-1:0]                    out_rows;
  logic [OC_W-1:0]                    out_cols;
  logic                               clear_after;
  logic                               activate;
  logic [ADDR_WIDTH-1:0]              wr_base_addr;
  logic                               stall;
  logic                               busy;
  logic                               done;
  logic [SM_W-1:0]                    submat_row_out;
  logic [SN_W-1:0]                    submat_col_out;
  logic [RN_W-1:0]                    row_num;
  logic                               relu_en;
  logic                               accum_clear;
  logic [SYS_ARR_COLS-1:0]            wr_en;
  logic [SYS_ARR_COLS*ADDR_WIDTH-1:0] wr_addr;

  modport slave (
    input  start, out_rows, out_cols, clear_after, activate, wr_base_addr, stall,
    output busy, done, submat_row_out, submat_col_out, row_num, relu_en,
           accum_clear, wr_en, wr_addr
  );

  modport master (
    output start, out_rows, out_cols, clear_after, activate, wr_base_addr, stall,
    input  busy, done, submat_row_out, submat_col_out, row_num, relu_en,
           accum_clear, wr_en, wr_addr
  );
endinterface

// File: rtl/master_output_sequencer.sv
// Drains a whole output matrix tile by tile (column tiles outer, row tiles
// middle, accumulator rows inner) into column-banked output memory.
module master_output_sequencer #(
  parameter int MAX_OUT_ROWS = 128,
  parameter int MAX_OUT_COLS = 128,
  parameter int SYS_ARR_ROWS = 16,
  parameter int SYS_ARR_COLS = 16,
  parameter int ADDR_WIDTH   = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  master_output_sequencer_if.slave  bus
);
  localparam int NUM_SUBMATS_M = MAX_OUT_ROWS / SYS_ARR_ROWS;
  localparam int NUM_SUBMATS_N = MAX_OUT_COLS / SYS_ARR_COLS;
  localparam int OR_W = $clog2(MAX_OUT_ROWS);
  localparam int OC_W = $clog2(MAX_OUT_COLS);
  localparam int SM_W = (NUM_SUBMATS_M > 1) ? $clog2(NUM_SUBMATS_M) : 1;
  localparam int SN_W = (NUM_SUBMATS_N > 1) ? $clog2(NUM_SUBMATS_N) : 1;
  localparam int RN_W = $clog2(SYS_ARR_ROWS);
  localparam int CN_W = $clog2(SYS_ARR_COLS);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t state, state_next;

  logic [OR_W-1:0]         rows_q;
  logic [OC_W-1:0]         cols_q;
  logic                    clear_q;
  logic                    act_q;
  logic [ADDR_WIDTH-1:0]   addr_cnt;
  logic [RN_W-1:0]         row_cnt;
  logic [SM_W-1:0]         srow;
  logic [SN_W-1:0]         scol;

  logic                    beat;
  logic                    last_row;
  logic                    last_row_tile;
  logic                    last_col_tile;
  logic                    last_beat;
  logic [RN_W-1:0]         tile_rows_m1;
  logic [CN_W-1:0]         col_rem;
  logic [SYS_ARR_COLS-1:0] tile_mask;

  // Edge tiles are the ones whose index equals the latched extent's tile index;
  // only those get a shortened row count or a narrowed bank mask.
  always_comb begin
    last_row_tile = (OR_W'(srow) == (rows_q >> RN_W));
    last_col_tile = (OC_W'(scol) == (cols_q >> CN_W));
    tile_rows_m1  = last_row_tile ? rows_q[RN_W-1:0] : '1;
    last_row      = (row_cnt == tile_rows_m1);
    last_beat     = last_row && last_row_tile && last_col_tile;
    col_rem       = cols_q[CN_W-1:0];
    tile_mask     = '1;
    if (last_col_tile) begin
      for (int i = 0; i < SYS_ARR_COLS; i++) begin
        tile_mask[i] = (i <= int'(col_rem));
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next      = state;
    beat            = 1'b0;
    bus.busy        = 1'b0;
    bus.done        = 1'b0;
    bus.wr_en       = '0;
    bus.relu_en     = 1'b0;
    bus.accum_clear = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) state_next = RUN;
      end
      RUN: begin
        bus.busy = 1'b1;
        beat     = !bus.stall;
        if (beat) begin
          bus.wr_en       = tile_mask;
          bus.relu_en     = act_q;
          bus.accum_clear = clear_q && last_row;
          if (last_beat) state_next = DONE;
        end
      end
      DONE: begin
        bus.done   = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Command fields are captured once so later input changes cannot disturb
  // a running drain; counters only move on non-stalled beats.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rows_q   <= '0;
      cols_q   <= '0;
      clear_q  <= 1'b0;
      act_q    <= 1'b0;
      addr_cnt <= '0;
      row_cnt  <= '0;
      srow     <= '0;
      scol     <= '0;
    end else if (state == IDLE && bus.start) begin
      rows_q   <= bus.out_rows;
      cols_q   <= bus.out_cols;
      clear_q  <= bus.clear_after;
      act_q    <= bus.activate;
      addr_cnt <= bus.wr_base_addr;
      row_cnt  <= '0;
      srow     <= '0;
      scol     <= '0;
    end else if (beat) begin
      addr_cnt <= addr_cnt + ADDR_WIDTH'(1);
      if (last_row) begin
        row_cnt <= '0;
        if (last_row_tile) begin
          srow <= '0;
          scol <= last_col_tile ? '0 : scol + SN_W'(1);
        end else begin
          srow <= srow + SM_W'(1);
        end
      end else begin
        row_cnt <= row_cnt + RN_W'(1);
      end
    end
  end

  assign bus.wr_addr        = {SYS_ARR_COLS{addr_cnt}};
  assign bus.row_num        = row_cnt;
  assign bus.submat_row_out = srow;
  assign bus.submat_col_out = scol;
endmodule

// File: tb/tb_master_output_sequencer.sv
// Randomised bench for master_output_sequencer: every beat is compared with a
// list of writes derived directly from the matrix shape and base address.
module tb_master_output_sequencer;
  logic clk;
  logic reset;
  int   vectors;
  int   miscompares;

  typedef struct {
    int addr;
    int mask;
    int rnum;
    int srow;
    int scol;
    bit clear;
  } beat_t;

  master_output_sequencer_if bus ();

  master_output_sequencer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive_idle();
    bus.start        = 1'b0;
    bus.out_rows     = '0;
    bus.out_cols     = '0;
    bus.clear_after  = 1'b0;
    bus.activate     = 1'b0;
    bus.wr_base_addr = '0;
    bus.stall        = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive_idle();
    repeat (2) @(negedge clk);
    vectors++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.wr_en !== 16'h0 ||
        bus.relu_en !== 1'b0 || bus.accum_clear !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_ctrl: got busy=%b done=%b wr_en=%h relu=%b clr=%b, want all 0",
               bus.busy, bus.done, bus.wr_en, bus.relu_en, bus.accum_clear);
    end
    vectors++;
    if (bus.wr_addr !== 128'h0 || bus.row_num !== 4'h0 ||
        bus.submat_row_out !== 3'h0 || bus.submat_col_out !== 3'h0) begin
      miscompares++;
      $display("[TB] FAIL reset_cnt: got addr=%h row=%0d tile=(%0d,%0d), want all 0",
               bus.wr_addr, bus.row_num, bus.submat_row_out, bus.submat_col_out);
    end
    reset = 1'b0;
    bus.stall = 1'b1;
    repeat (2) @(negedge clk);
    vectors++;
    if (bus.busy !== 1'b0 || bus.wr_en !== 16'h0 || bus.done !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL idle_after_reset: got busy=%b wr_en=%h done=%b, want 0/0/0",
               bus.busy, bus.wr_en, bus.done);
    end
    bus.stall = 1'b0;
  endtask

  // stall_mode: 0 none, 1 cycles 3..5, 2 random; glitch pulses start in cycle 5.
  task automatic run_cmd(input int rows, input int cols, input int base,
                         input bit clr, input bit act, input int stall_mode,
                         input bit glitch);
    beat_t       exp[$];
    beat_t       e;
    int          n_ct;
    int          idx;
    int          cyc;
    bit          st;
    logic [7:0]  a8;
    logic [127:0] ea;

    n_ct = cols / 16 + 1;
    for (int c = 0; c < n_ct; c++) begin
      for (int r = 0; r <= rows; r++) begin
        e.addr  = (base + c * (rows + 1) + r) % 256;
        e.mask  = (c == n_ct - 1) ? ((1 << (cols % 16 + 1)) - 1) : 'hFFFF;
        e.rnum  = r % 16;
        e.srow  = r / 16;
        e.scol  = c;
        e.clear = clr && ((r % 16 == 15) || (r == rows));
        exp.push_back(e);
      end
    end

    @(negedge clk);
    bus.out_rows     = 7'(rows);
    bus.out_cols     = 7'(cols);
    bus.wr_base_addr = 8'(base);
    bus.clear_after  = clr;
    bus.activate     = act;
    bus.start        = 1'b1;
    @(posedge clk);
    #1;
    bus.start        = 1'b0;
    bus.out_rows     = 7'($urandom);
    bus.out_cols     = 7'($urandom);
    bus.wr_base_addr = 8'($urandom);
    bus.clear_after  = ~clr;
    bus.activate     = ~act;

    idx = 0;
    cyc = 1;
    while (idx < exp.size()) begin
      st = (stall_mode == 1) ? (cyc >= 3 && cyc <= 5) :
           (stall_mode == 2) ? ($urandom_range(0, 3) == 0) : 1'b0;
      bus.stall = st;
      bus.start = glitch && (cyc == 5);
      @(negedge clk);
      e  = exp[idx];
      a8 = 8'(e.addr);
      ea = {16{a8}};
      vectors++;
      if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL run_status cyc=%0d: got busy=%b done=%b, want 1/0",
                 cyc, bus.busy, bus.done);
      end
      vectors++;
      if (bus.wr_addr !== ea || bus.row_num !== 4'(e.rnum) ||
          bus.submat_row_out !== 3'(e.srow) || bus.submat_col_out !== 3'(e.scol)) begin
        miscompares++;
        $display("[TB] FAIL beat_pos cyc=%0d: got addr=%h row=%0d tile=(%0d,%0d), want addr=%h row=%0d tile=(%0d,%0d)",
                 cyc, bus.wr_addr[7:0], bus.row_num, bus.submat_row_out, bus.submat_col_out,
                 a8, e.rnum, e.srow, e.scol);
      end
      vectors++;
      if (st) begin
        if (bus.wr_en !== 16'h0 || bus.relu_en !== 1'b0 || bus.accum_clear !== 1'b0) begin
          miscompares++;
          $display("[TB] FAIL stall_ctrl cyc=%0d: got wr_en=%h relu=%b clr=%b, want 0/0/0",
                   cyc, bus.wr_en, bus.relu_en, bus.accum_clear);
        end
      end else begin
        if (bus.wr_en !== 16'(e.mask) || bus.relu_en !== act || bus.accum_clear !== e.clear) begin
          miscompares++;
          $display("[TB] FAIL beat_ctrl cyc=%0d: got wr_en=%h relu=%b clr=%b, want %h/%b/%b",
                   cyc, bus.wr_en, bus.relu_en, bus.accum_clear, 16'(e.mask), act, e.clear);
        end
        idx++;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    bus.stall = 1'b0;
    bus.start = 1'b0;
    @(negedge clk);
    vectors++;
    if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.wr_en !== 16'h0) begin
      miscompares++;
      $display("[TB] FAIL done_pulse cyc=%0d: got done=%b busy=%b wr_en=%h, want 1/0/0",
               cyc, bus.done, bus.busy, bus.wr_en);
    end
    @(posedge clk);
    #1;
    @(negedge clk);
    vectors++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL done_single cyc=%0d: got done=%b busy=%b, want 0/0",
               cyc + 1, bus.done, bus.busy);
    end
  endtask

  task automatic test_full_tile();
    run_cmd(15, 15, 8, 1'b1, 1'b0, 0, 1'b0);
  endtask

  task automatic test_partial_edges();
    run_cmd(19, 20, 0, 1'b1, 1'b1, 0, 1'b0);
  endtask

  task automatic test_stall();
    run_cmd(15, 15, 8, 1'b1, 1'b0, 1, 1'b0);
  endtask

  task automatic test_addr_wrap();
    run_cmd(15, 15, 250, 1'b0, 1'b1, 0, 1'b0);
  endtask

  task automatic test_start_ignored();
    run_cmd(19, 20, 5, 1'b0, 1'b0, 0, 1'b1);
  endtask

  task automatic test_reset_abort();
    @(negedge clk);
    bus.out_rows     = 7'd15;
    bus.out_cols     = 7'd15;
    bus.wr_base_addr = 8'd8;
    bus.clear_after  = 1'b1;
    bus.activate     = 1'b1;
    bus.start        = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    vectors++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.wr_en !== 16'h0 ||
        bus.relu_en !== 1'b0 || bus.accum_clear !== 1'b0 || bus.wr_addr !== 128'h0 ||
        bus.row_num !== 4'h0 || bus.submat_row_out !== 3'h0 || bus.submat_col_out !== 3'h0) begin
      miscompares++;
      $display("[TB] FAIL abort_outputs: got busy=%b done=%b wr_en=%h relu=%b addr=%h row=%0d, want all 0",
               bus.busy, bus.done, bus.wr_en, bus.relu_en, bus.wr_addr[7:0], bus.row_num);
    end
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      vectors++;
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL abort_no_done i=%0d: got done=%b busy=%b, want 0/0",
                 i, bus.done, bus.busy);
      end
    end
    run_cmd(15, 15, 40, 1'b1, 1'b0, 0, 1'b0);
  endtask

  task automatic test_back_to_back();
    run_cmd(3, 40, 100, 1'b1, 1'b1, 0, 1'b0);
    run_cmd(33, 7, 200, 1'b0, 1'b0, 2, 1'b0);
  endtask

  task automatic test_random();
    for (int k = 0; k < 6; k++) begin
      run_cmd($urandom_range(0, 47), $urandom_range(0, 127), $urandom_range(0, 255),
              1'($urandom), 1'($urandom), 2, 1'($urandom));
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset();
    test_full_tile();
    test_partial_edges();
    test_stall();
    test_addr_wrap();
    test_start_ignored();
    test_reset_abort();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
